// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and the load-value clamp used by the
// cascaded BCD counter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX    = 4'd9;
    localparam bcd_digit_t BCD_MIN    = 4'd0;
    localparam int         MAX_DIGITS = 8;

    // Non-decimal nibbles (10..15) collapse to the largest legal digit.
    function automatic bcd_digit_t bcd_clamp(input logic [3:0] raw);
        return (raw > BCD_MAX) ? BCD_MAX : bcd_digit_t'(raw);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the cascade: load, up/down step and carry/borrow out.
// co is combinational so a full-width ripple settles within one clock.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       dir,
    input  logic       ld,
    input  logic [3:0] ld_val,
    output bcd_digit_t value,
    output logic       co
);

    bcd_digit_t r_value;
    bcd_digit_t w_value_next;

    always_comb begin
        w_value_next = r_value;
        if (ld) begin
            w_value_next = bcd_clamp(ld_val);
        end else if (step) begin
            if (dir) begin
                w_value_next = (r_value >= BCD_MAX) ? BCD_MIN : r_value + 4'd1;
            end else begin
                w_value_next = (r_value == BCD_MIN) ? BCD_MAX : r_value - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= BCD_MIN;
        end else begin
            r_value <= w_value_next;
        end
    end

    // A stepped digit sitting on its rollover value passes the step upward.
    assign co    = step & (dir ? (r_value == BCD_MAX) : (r_value == BCD_MIN));
    assign value = r_value;

endmodule

// File: rtl/multi_digit_bcd_counter.sv
// Cascaded up/down BCD counter with parallel load, terminal-count flag and
// load-error flag. Define BCD_COUNTER_SAT_EN to saturate instead of wrapping.
module multi_digit_bcd_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                sel,
    input  logic                load,
    input  logic [4*DIGITS-1:0] din,
    output logic [4*DIGITS-1:0] q,
    output logic                tc,
    output logic                load_err
);

    logic [DIGITS:0]   w_step;
    logic [DIGITS-1:0] w_din_bad;
    logic              r_load_err;

`ifdef BCD_COUNTER_SAT_EN
    logic [DIGITS-1:0] w_is_max;
    logic [DIGITS-1:0] w_is_min;
    logic              w_term;

    assign w_term    = sel ? (&w_is_max) : (&w_is_min);
    // At the end of the range the step is swallowed so q holds.
    assign w_step[0] = en & ~load & ~w_term;
    assign tc        = ~rst & en & ~load & w_term;
`else
    assign w_step[0] = en & ~load;
    // A step that ripples out of the top digit means every digit was terminal.
    assign tc        = ~rst & w_step[DIGITS];
`endif

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        bcd_digit u_digit (
            .clk    (clk),
            .rst    (rst),
            .step   (w_step[gi]),
            .dir    (sel),
            .ld     (load),
            .ld_val (din[4*gi +: 4]),
            .value  (q[4*gi +: 4]),
            .co     (w_step[gi+1])
        );

        assign w_din_bad[gi] = (din[4*gi +: 4] > BCD_MAX);

`ifdef BCD_COUNTER_SAT_EN
        assign w_is_max[gi] = (q[4*gi +: 4] == BCD_MAX);
        assign w_is_min[gi] = (q[4*gi +: 4] == BCD_MIN);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= load & (|w_din_bad);
        end
    end

    assign load_err = r_load_err;

endmodule

// File: tb/tb_multi_digit_bcd_counter.sv
// Self-checking bench: directed scenarios plus randomized traffic on a 2-digit
// and a 4-digit counter, checked against a decimal-arithmetic reference model.
module tb_multi_digit_bcd_counter;

    logic        clk = 1'b0;
    logic        rst2 = 1'b0, en2 = 1'b0, sel2 = 1'b0, load2 = 1'b0;
    logic [7:0]  din2 = '0;
    logic [7:0]  q2;
    logic        tc2, le2;
    logic        rst4 = 1'b0, en4 = 1'b0, sel4 = 1'b0, load4 = 1'b0;
    logic [15:0] din4 = '0;
    logic [15:0] q4;
    logic        tc4, le4;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    // Reference model state: counter value as a plain decimal integer.
    int mq2 = 0, mq4 = 0;
    bit mle2 = 1'b0, mle4 = 1'b0;
    bit tco2, tcx2, tco4, tcx4;

    always #5 clk = ~clk;

    multi_digit_bcd_counter #(.DIGITS(2)) u_dut2 (
        .clk(clk), .rst(rst2), .en(en2), .sel(sel2), .load(load2),
        .din(din2), .q(q2), .tc(tc2), .load_err(le2)
    );

    multi_digit_bcd_counter #(.DIGITS(4)) u_dut4 (
        .clk(clk), .rst(rst4), .en(en4), .sel(sel4), .load(load4),
        .din(din4), .q(q4), .tc(tc4), .load_err(le4)
    );

    function automatic int p10(input int d);
        int r = 1;
        for (int i = 0; i < d; i++) r = r * 10;
        return r;
    endfunction

    function automatic int din_val(input logic [31:0] din, input int d);
        int n = 0;
        for (int i = d - 1; i >= 0; i--) begin
            logic [3:0] dg;
            dg = din[4*i +: 4];
            n = n * 10 + ((dg > 4'd9) ? 9 : int'(dg));
        end
        return n;
    endfunction

    function automatic bit din_bad(input logic [31:0] din, input int d);
        bit bad = 1'b0;
        for (int i = 0; i < d; i++) begin
            logic [3:0] dg;
            dg = din[4*i +: 4];
            if (dg > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic [31:0] to_bcd(input int n, input int d);
        logic [31:0] r = '0;
        int v = n;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int next_val(input int n, input int d, input bit r, input bit l,
                                    input bit e, input bit s, input logic [31:0] din);
        int top = p10(d) - 1;
        if (r) return 0;
        if (l) return din_val(din, d);
        if (!e) return n;
`ifdef BCD_COUNTER_SAT_EN
        if (s) return (n == top) ? n : n + 1;
        return (n == 0) ? n : n - 1;
`else
        if (s) return (n == top) ? 0 : n + 1;
        return (n == 0) ? top : n - 1;
`endif
    endfunction

    function automatic bit tc_model(input int n, input int d, input bit r, input bit l,
                                    input bit e, input bit s);
        return !r && !l && e && (s ? (n == p10(d) - 1) : (n == 0));
    endfunction

    // One clock: sample tc before the edge, advance the model, sample after.
    task automatic tick();
        #1;
        tco2 = tc2;
        tcx2 = tc_model(mq2, 2, rst2, load2, en2, sel2);
        tco4 = tc4;
        tcx4 = tc_model(mq4, 4, rst4, load4, en4, sel4);
        mle2 = !rst2 && load2 && din_bad({24'b0, din2}, 2);
        mle4 = !rst4 && load4 && din_bad({16'b0, din4}, 4);
        mq2  = next_val(mq2, 2, rst2, load2, en2, sel2, {24'b0, din2});
        mq4  = next_val(mq4, 4, rst4, load4, en4, sel4, {16'b0, din4});
        @(posedge clk);
        #1;
        txn++;
        $display("txn %0d d2 rst=%0b ld=%0b en=%0b sel=%0b din=%h q=%h tc=%0b le=%0b | d4 rst=%0b ld=%0b en=%0b sel=%0b din=%h q=%h tc=%0b le=%0b",
                 txn, rst2, load2, en2, sel2, din2, q2, tco2, le2,
                 rst4, load4, en4, sel4, din4, q4, tco4, le4);
    endtask

    task automatic test_reset();
        rst2 = 1'b1; en2 = 1'b1; sel2 = 1'b0; load2 = 1'b0;
        rst4 = 1'b1; en4 = 1'b1; sel4 = 1'b0; load4 = 1'b0;
        tick();
        checks++;
        if (tco2 !== 1'b0) begin failures++; $display("FAIL reset_tc got=%b exp=0", tco2); end
        checks++;
        if (q2 !== 8'h00) begin failures++; $display("FAIL reset_q2 got=%h exp=00", q2); end
        checks++;
        if (le2 !== 1'b0) begin failures++; $display("FAIL reset_le got=%b exp=0", le2); end
        checks++;
        if (q4 !== 16'h0000) begin failures++; $display("FAIL reset_q4 got=%h exp=0000", q4); end
        rst2 = 1'b0; en2 = 1'b0;
        rst4 = 1'b0; en4 = 1'b0;
    endtask

    task automatic test_count_up();
        en2 = 1'b1; sel2 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (tco2 !== 1'b0) begin failures++; $display("FAIL count_up_tc step=%0d got=%b exp=0", i, tco2); end
        end
        checks++;
        if (q2 !== 8'h12) begin failures++; $display("FAIL count_up_q got=%h exp=12", q2); end
        en2 = 1'b0;
    endtask

    task automatic test_terminal();
        logic [7:0] exp_q;
        load2 = 1'b1; din2 = 8'h99;
        tick();
        checks++;
        if (q2 !== 8'h99) begin failures++; $display("FAIL term_load_q got=%h exp=99", q2); end
        load2 = 1'b0; en2 = 1'b1; sel2 = 1'b1;
        tick();
`ifdef BCD_COUNTER_SAT_EN
        exp_q = 8'h99;
`else
        exp_q = 8'h00;
`endif
        checks++;
        if (tco2 !== 1'b1) begin failures++; $display("FAIL term_up_tc got=%b exp=1", tco2); end
        checks++;
        if (q2 !== exp_q) begin failures++; $display("FAIL term_up_q got=%h exp=%h", q2, exp_q); end
        en2 = 1'b0; load2 = 1'b1; din2 = 8'h00;
        tick();
        load2 = 1'b0; en2 = 1'b1; sel2 = 1'b0;
        tick();
`ifdef BCD_COUNTER_SAT_EN
        exp_q = 8'h00;
`else
        exp_q = 8'h99;
`endif
        checks++;
        if (tco2 !== 1'b1) begin failures++; $display("FAIL term_down_tc got=%b exp=1", tco2); end
        checks++;
        if (q2 !== exp_q) begin failures++; $display("FAIL term_down_q got=%h exp=%h", q2, exp_q); end
        en2 = 1'b0;
    endtask

    task automatic test_borrow();
        load2 = 1'b1; din2 = 8'h10;
        tick();
        load2 = 1'b0; en2 = 1'b1; sel2 = 1'b0;
        tick();
        checks++;
        if (q2 !== 8'h09) begin failures++; $display("FAIL borrow_q1 got=%h exp=09", q2); end
        checks++;
        if (tco2 !== 1'b0) begin failures++; $display("FAIL borrow_tc got=%b exp=0", tco2); end
        tick();
        checks++;
        if (q2 !== 8'h08) begin failures++; $display("FAIL borrow_q2 got=%h exp=08", q2); end
        en2 = 1'b0;
    endtask

    task automatic test_load_clamp();
        load2 = 1'b1; din2 = 8'hA5;
        tick();
        checks++;
        if (q2 !== 8'h95) begin failures++; $display("FAIL clamp_q got=%h exp=95", q2); end
        checks++;
        if (le2 !== 1'b1) begin failures++; $display("FAIL clamp_le_set got=%b exp=1", le2); end
        load2 = 1'b0;
        tick();
        checks++;
        if (le2 !== 1'b0) begin failures++; $display("FAIL clamp_le_clear got=%b exp=0", le2); end
        checks++;
        if (q2 !== 8'h95) begin failures++; $display("FAIL clamp_hold_q got=%h exp=95", q2); end
        load2 = 1'b1; din2 = 8'hFB;
        tick();
        checks++;
        if (q2 !== 8'h99) begin failures++; $display("FAIL clamp_ff_q got=%h exp=99", q2); end
        load2 = 1'b1; din2 = 8'h37;
        tick();
        checks++;
        if (le2 !== 1'b0) begin failures++; $display("FAIL back_to_back_le got=%b exp=0", le2); end
        checks++;
        if (q2 !== 8'h37) begin failures++; $display("FAIL back_to_back_q got=%h exp=37", q2); end
        load2 = 1'b0;
    endtask

    task automatic test_priority();
        load2 = 1'b1; din2 = 8'h99;
        tick();
        en2 = 1'b1; sel2 = 1'b1; load2 = 1'b1; din2 = 8'h42;
        tick();
        checks++;
        if (tco2 !== 1'b0) begin failures++; $display("FAIL prio_load_tc got=%b exp=0", tco2); end
        checks++;
        if (q2 !== 8'h42) begin failures++; $display("FAIL prio_load_q got=%h exp=42", q2); end
        rst2 = 1'b1; din2 = 8'hA2;
        tick();
        checks++;
        if (q2 !== 8'h00) begin failures++; $display("FAIL prio_rst_q got=%h exp=00", q2); end
        checks++;
        if (le2 !== 1'b0) begin failures++; $display("FAIL prio_rst_le got=%b exp=0", le2); end
        checks++;
        if (tco2 !== 1'b0) begin failures++; $display("FAIL prio_rst_tc got=%b exp=0", tco2); end
        rst2 = 1'b0; load2 = 1'b0; en2 = 1'b0;
    endtask

    task automatic test_ripple_dir();
        logic [15:0] exp_q;
        load4 = 1'b1; din4 = 16'h0999;
        tick();
        load4 = 1'b0; en4 = 1'b1; sel4 = 1'b1;
        tick();
        checks++;
        if (q4 !== 16'h1000) begin failures++; $display("FAIL ripple_up_q got=%h exp=1000", q4); end
        for (int k = 0; k < 6; k++) begin
            sel4  = (k % 2 == 0) ? 1'b0 : 1'b1;
            exp_q = sel4 ? 16'h1000 : 16'h0999;
            tick();
            checks++;
            if (q4 !== exp_q) begin failures++; $display("FAIL ripple_toggle k=%0d got=%h exp=%h", k, q4, exp_q); end
        end
        en4 = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0]  eq2;
        logic [15:0] eq4;
        logic [3:0]  dg;
        for (int n = 0; n < 400; n++) begin
            rst2  = ($urandom_range(0, 31) == 0);
            load2 = ($urandom_range(0, 6) == 0);
            en2   = ($urandom_range(0, 3) != 0);
            sel2  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: din2 = 8'h99;
                1: din2 = 8'h00;
                default: din2 = 8'($urandom);
            endcase
            rst4  = ($urandom_range(0, 31) == 0);
            load4 = ($urandom_range(0, 6) == 0);
            en4   = ($urandom_range(0, 3) != 0);
            sel4  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: din4 = 16'h9999;
                1: din4 = 16'h0000;
                default: din4 = 16'($urandom);
            endcase
            tick();
            eq2 = 8'(to_bcd(mq2, 2));
            eq4 = 16'(to_bcd(mq4, 4));
            checks++;
            if (q2 !== eq2) begin failures++; $display("FAIL rand_q2 n=%0d got=%h exp=%h", n, q2, eq2); end
            checks++;
            if (tco2 !== tcx2) begin failures++; $display("FAIL rand_tc2 n=%0d got=%b exp=%b", n, tco2, tcx2); end
            checks++;
            if (le2 !== mle2) begin failures++; $display("FAIL rand_le2 n=%0d got=%b exp=%b", n, le2, mle2); end
            checks++;
            if (q4 !== eq4) begin failures++; $display("FAIL rand_q4 n=%0d got=%h exp=%h", n, q4, eq4); end
            checks++;
            if (tco4 !== tcx4) begin failures++; $display("FAIL rand_tc4 n=%0d got=%b exp=%b", n, tco4, tcx4); end
            checks++;
            if (le4 !== mle4) begin failures++; $display("FAIL rand_le4 n=%0d got=%b exp=%b", n, le4, mle4); end
            for (int i = 0; i < 4; i++) begin
                dg = q4[4*i +: 4];
                checks++;
                if (!(dg <= 4'd9)) begin failures++; $display("FAIL rand_digit4 n=%0d idx=%0d got=%h exp<=9", n, i, dg); end
            end
        end
        rst2 = 1'b0; load2 = 1'b0; en2 = 1'b0;
        rst4 = 1'b0; load4 = 1'b0; en4 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_terminal();
        test_borrow();
        test_load_clamp();
        test_priority();
        test_ripple_dir();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_digit_bcd_counter.md
MULTI_DIGIT_BCD_COUNTER -- requirements
Module: multi_digit_bcd_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, meaning number of cascaded BCD digits (legal range 1..8).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock, sole clock of the block.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 The block SHALL have port en  input  1  count enable; count step taken only when high.
REQ-005 The block SHALL have port sel  input  1  direction; 1 = count up, 0 = count down.
REQ-006 The block SHALL have port load  input  1  synchronous parallel load strobe.
REQ-007 The block SHALL have port din  input  4*DIGITS  load value, digit 0 in bits [3:0], packed BCD.
REQ-008 The block SHALL have port q  output  4*DIGITS  registered count, packed BCD, digit 0 least significant.
REQ-009 The block SHALL have port tc  output  1  terminal-count flag, combinational.
REQ-010 The block SHALL have port load_err  output  1  registered one-cycle flag: last load held a non-BCD digit.

Function
REQ-011 Priority on each rising clk SHALL be rst > load > en; en ignored in a load cycle.
REQ-012 Up step: digit 0 +1; digit at 9 SHALL become 0 and carry +1 into next digit; ripple resolves within one cycle.
REQ-013 Down step: digit 0 -1; digit at 0 SHALL become 9 and borrow from next digit; ripple resolves within one cycle.
REQ-014 Latency: q SHALL reflect a step or load on the clk edge where it is sampled (one-cycle update, no pipeline).
REQ-015 Wrap (default build): all-9s up SHALL go to all-0s; all-0s down SHALL go to all-9s.
REQ-016 tc SHALL be high when en=1, load=0, rst=0 and q is all-9s with sel=1, or all-0s with sel=0; else low.
REQ-017 Load: each din digit 0..9 SHALL be copied; each digit 10..15 SHALL be loaded as 9.
REQ-018 load_err SHALL be high for exactly the cycle after a load containing any digit >9; low otherwise.
REQ-019 sel changes SHALL take effect on the next enabled step with no lost or extra counts.
REQ-020 q SHALL never hold a digit value >9 under any input sequence.

Reset
REQ-021 On rst=1 at a clk edge, q SHALL become all-0s and load_err SHALL become 0, regardless of load/en.
REQ-022 Reset mid-ripple or mid-load SHALL fully override; no partial digit update retained.
REQ-023 tc SHALL be 0 while rst=1.

Configuration
REQ-024 Macro BCD_COUNTER_SAT_EN SHALL select saturating mode when defined.
REQ-025 With BCD_COUNTER_SAT_EN defined: up at all-9s and down at all-0s SHALL hold q unchanged; tc SHALL still assert per REQ-016.
REQ-026 Without BCD_COUNTER_SAT_EN: wrap behaviour per REQ-015; no saturation logic present.

Structure
REQ-027 Package bcd_pkg SHALL hold the digit type (4-bit), BCD_MAX = 9, BCD_MIN = 0, and MAX_DIGITS = 8.
REQ-028 Sub-module bcd_digit SHALL implement one digit: inputs step, dir, ld, ld_val; outputs value, carry/borrow-out; instantiated DIGITS times by generate.
REQ-029 Terminal detection and load_err SHALL reside in the top level, not in bcd_digit.

Verification (DIGITS=2 unless noted)
REQ-030 rst=1 one cycle, then en=1, sel=1 for 12 cycles -> q=0x12, tc low throughout.
REQ-031 load din=0x99, then en=1, sel=1 one cycle -> tc high during that cycle, q=0x00 after (SAT build: q stays 0x99).
REQ-032 load din=0x10, then en=1, sel=0 one cycle -> q=0x09 (borrow across digit); second down cycle -> q=0x08.
REQ-033 load din=0xA5 -> q=0x95, load_err high exactly one cycle, then low.
REQ-034 en=1, sel=1, load=1, din=0x42 same cycle -> q=0x42 (load wins, no step); rst=1 with load=1 -> q=0x00.
REQ-035 DIGITS=4, load din=0x0999, en=1, sel=1 one cycle -> q=0x1000; toggle sel each cycle for 6 cycles -> q alternates 0x0999/0x1000.
